// File: rtl/vector_append_pkg.sv
// Shared types and bit-manipulation helpers for the vector append stream.
package vector_append_pkg;

  // Widest half-word the reverse helpers handle; callers pass their real width.
  localparam int MAX_W = 512;

  typedef enum logic [1:0] {
    MODE_APPEND      = 2'd0,
    MODE_BYTEREV_PAD = 2'd1,
    MODE_BITREV      = 2'd2,
    MODE_SWAP        = 2'd3
  } mode_e;

  function automatic logic [MAX_W-1:0] byte_rev(input logic [MAX_W-1:0] x,
                                                input int nbytes);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = x[8*(nbytes-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] x,
                                               input int nbits);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r[i] = x[nbits-1-i];
    return r;
  endfunction

endpackage

// File: rtl/vappend_fifo.sv
// Result buffer: DEPTH-entry circular FIFO with registered occupancy;
// the head reads as zero while empty.
module vappend_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [W-1:0]               push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign push_ready = (count_q < FULL_CNT);
  assign pop_valid  = (count_q != '0);
  assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    push     = push_valid & push_ready;
    pop      = pop_valid & pop_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy gates every read, so
  // stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vector_append_stream.sv
// Combines the upper half of operand A with the lower half of operand B under
// one of four transforms, then queues results in an output buffer.
module vector_append_stream
  import vector_append_pkg::*;
#(
  parameter int W     = 64,
  parameter int PAD   = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               __in0,
  input  logic [W-1:0]               __in1,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               __out0,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                xfer_cnt
);

  localparam int HW = W / 2;

  logic [HW-1:0]    h, l;
  logic [MAX_W-1:0] h_byterev_full, h_bitrev_full;
  logic [W-1:0]     result;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;
  logic             unused_bits;

  assign h = __in0[W-1:HW];
  assign l = __in1[HW-1:0];

  always_comb begin
    h_byterev_full = byte_rev(MAX_W'(h), HW / 8);
    h_bitrev_full  = bit_rev(MAX_W'(h), HW);
    result         = {h, l};
    case (mode_e'(mode))
      MODE_APPEND:      result = {h, l};
      MODE_BYTEREV_PAD: result = {h_byterev_full[HW-1:0], {PAD{1'b0}},
                                  __in1[HW-PAD-1:0]};
      MODE_BITREV:      result = {h_bitrev_full[HW-1:0], l};
      MODE_SWAP:        result = {l, h};
      default:          result = {h, l};
    endcase
  end

  // Operand halves outside H/L and the helpers' spare high bits are don't-care.
  assign unused_bits = ^{__in0[HW-1:0], __in1[W-1:HW], h_byterev_full, h_bitrev_full};

  vappend_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (result),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (__out0),
    .count      (count)
  );

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_valid && out_ready) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= '0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_vector_append_stream.sv
// Directed bench for vector_append_stream with hand-computed expected results.
module tb_vector_append_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in0, in1;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out0;
  logic [2:0]  count;
  logic [15:0] xfer_cnt;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [63:0] A    = 64'h0123456789ABCDEF;
  localparam logic [63:0] B    = 64'hFEDCBA9876543210;
  localparam logic [63:0] R_M0 = 64'h0123456776543210;
  localparam logic [63:0] R_M1 = 64'h6745230100543210;
  localparam logic [63:0] R_M2 = 64'hE6A2C48076543210;
  localparam logic [63:0] R_M3 = 64'h7654321001234567;
  // Operands swapped, mode 0: H=FEDCBA98, L=89ABCDEF.
  localparam logic [63:0] R_SW = 64'hFEDCBA9889ABCDEF;

  vector_append_stream #(.W(64), .PAD(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .__in0     (in0),
    .__in1     (in1),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .__out0    (out0),
    .count     (count),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'd0; in0 = A; in1 = B;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out0",      out0,           64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_count",     64'(count),     64'd0);
    check("rst_xfer",      64'(xfer_cnt),  64'd0);

    // Mode 1: single handshake, one-cycle latency.
    in_valid = 1'b1; mode = 2'd1;
    tick();
    in_valid = 1'b0;
    check("m1_out_valid", 64'(out_valid), 64'd1);
    check("m1_out0",      out0,           R_M1);
    check("m1_count",     64'(count),     64'd1);
    rst = 1'b1; tick(); rst = 1'b0;

    // Modes 0, 2, 3 back-to-back with the consumer always ready.
    out_ready = 1'b1; in_valid = 1'b1; mode = 2'd0;
    tick();
    check("b2b_out0_m0", out0, R_M0);
    mode = 2'd2;
    tick();
    check("b2b_out0_m2",  out0,          R_M2);
    check("b2b_count_pp", 64'(count),    64'd1);
    mode = 2'd3;
    tick();
    check("b2b_out0_m3", out0, R_M3);
    in_valid = 1'b0;
    tick();
    check("b2b_xfer",  64'(xfer_cnt), 64'd3);
    check("b2b_empty", 64'(count),    64'd0);

    // Fill to DEPTH with the consumer stalled; the fifth pair must wait.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      tick();
    end
    in0 = B; in1 = A; mode = 2'd0;
    tick();
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count",    64'(count),    64'd4);
    check("full_hold",     out0,          R_M0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_head",  out0,       R_M1);
    tick();
    in_valid = 1'b0;
    check("full_push_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    tick();
    check("order_2", out0, R_M2);
    tick();
    check("order_3", out0, R_M3);
    tick();
    check("order_4", out0, R_SW);
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_xfer",  64'(xfer_cnt),  64'd8);
    in0 = A; in1 = B;

    // Reset with three buffered results and a handshake in the reset cycle.
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0;
    tick(); tick(); tick();
    check("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_count", 64'(count),     64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out0",  out0,           64'd0);
    check("mid_rst_xfer",  64'(xfer_cnt),  64'd0);

    // Consumer ready while empty: nothing pops.
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("empty_pop_xfer",  64'(xfer_cnt), 64'd0);
    check("empty_pop_count", 64'(count),    64'd0);

    // 65536 handshakes wrap xfer_cnt back to zero.
    in_valid = 1'b1; mode = 2'd3;
    for (int i = 0; i < 65536; i++) tick();
    check("wrap_ffff", 64'(xfer_cnt), 64'hFFFF);
    in_valid = 1'b0;
    tick();
    check("wrap_zero",  64'(xfer_cnt), 64'd0);
    check("wrap_count", 64'(count),    64'd0);
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("wrap_one", 64'(xfer_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
